sr_cmd_debouncer: RTL and testbench

//   Upstream command stage for the clocked SR flip-flop (FlipFlop_SR). Takes two raw,

---
 rtl/sr_cmd_debouncer_pkg.sv | 16 +
 rtl/sr_cmd_debouncer_debounce_channel.sv | 90 +++++++++
 rtl/sr_cmd_debouncer.sv | 86 ++++++++
 tb/tb_sr_cmd_debouncer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_cmd_debouncer_pkg.sv
// Shared definitions for the SR command debouncer: channel FSM state encoding and
// arbitration priority codes.
package sr_cmd_debouncer_pkg;

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      PRESS_CHK   = 2'd1,
      PRESSED     = 2'd2,
      RELEASE_CHK = 2'd3
   } deb_state_e;

   localparam int PRIO_DROP = 0;
   localparam int PRIO_SET  = 1;
   localparam int PRIO_RST  = 2;

endpackage

// File: rtl/sr_cmd_debouncer_debounce_channel.sv
// One button channel: 2-FF synchronizer, debounce FSM with a down-counting stability
// timer, debounced level and a one-cycle combinational press event.
//
//   state       | meaning
//   ------------+------------------------------------------------------------
//   RELEASED    | button considered up, waiting for sync high
//   PRESS_CHK   | sync high, timing stability before accepting a press
//   PRESSED     | press accepted (event fired on entry), level = 1
//   RELEASE_CHK | sync low, timing stability before accepting a release
module debounce_channel
   import sr_cmd_debouncer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic level,
   output logic press_evt
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]       sync_q, sync_d;
   deb_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sync;

   assign sync = sync_q[1];

   // Timer is loaded on entry to a check state and counts down to a terminal zero,
   // giving the same DEBOUNCE_CYCLES-edge window as an up-count to DEBOUNCE_CYCLES-1.
   always_comb begin
      sync_d    = {sync_q[0], btn};
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_evt = 1'b0;
      case (state_q)
         RELEASED: begin
            if (sync) begin
               state_d = PRESS_CHK;
               cnt_d   = CNT_LOAD;
            end
         end
         PRESS_CHK: begin
            if (!sync) begin
               state_d = RELEASED;
            end else if (cnt_q == '0) begin
               state_d   = PRESSED;
               press_evt = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         PRESSED: begin
            if (!sync) begin
               state_d = RELEASE_CHK;
               cnt_d   = CNT_LOAD;
            end
         end
         RELEASE_CHK: begin
            if (sync) begin
               state_d = PRESSED;
            end else if (cnt_q == '0) begin
               state_d = RELEASED;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: state_d = RELEASED;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= 2'b00;
         state_q <= RELEASED;
         cnt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = (state_q == PRESSED) || (state_q == RELEASE_CHK);

endmodule

// File: rtl/sr_cmd_debouncer.sv
// Debounces raw set/reset buttons into registered one-cycle S/R pulses, never both high.
// Optional SR_CMD_CONFLICT_EN adds a conflict pulse when both presses coincide.
module sr_cmd_debouncer
   import sr_cmd_debouncer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int PRIORITY        = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_set,
   input  logic btn_rst,
   output logic S,
   output logic R,
   output logic set_level,
   output logic rst_level
`ifdef SR_CMD_CONFLICT_EN
   ,
   output logic conflict
`endif
);

   logic set_evt, rst_evt, both_evt;
   logic s_q, s_d, r_q, r_d;

   debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn       (btn_set),
      .level     (set_level),
      .press_evt (set_evt)
   );

   debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn       (btn_rst),
      .level     (rst_level),
      .press_evt (rst_evt)
   );

   assign both_evt = set_evt & rst_evt;

   // Lone events pass straight through; only a same-cycle collision is arbitrated.
   always_comb begin
      s_d = set_evt & ~rst_evt;
      r_d = rst_evt & ~set_evt;
      if (both_evt) begin
         if (PRIORITY == PRIO_SET) begin
            s_d = 1'b1;
         end else if (PRIORITY == PRIO_RST) begin
            r_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q <= 1'b0;
         r_q <= 1'b0;
      end else begin
         s_q <= s_d;
         r_q <= r_d;
      end
   end

   assign S = s_q;
   assign R = r_q;

`ifdef SR_CMD_CONFLICT_EN
   logic conflict_q, conflict_d;

   assign conflict_d = both_evt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_q <= 1'b0;
      end else begin
         conflict_q <= conflict_d;
      end
   end

   assign conflict = conflict_q;
`endif

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// Directed bench for sr_cmd_debouncer with DEBOUNCE_CYCLES=4 and one instance per PRIORITY.
module tb_sr_cmd_debouncer;

   logic clk;
   logic rst_n;
   logic btn_set;
   logic btn_rst;
   logic s0, r0, sl0, rl0;
   logic s1, r1, sl1, rl1;
   logic s2, r2, sl2, rl2;
`ifdef SR_CMD_CONFLICT_EN
   logic cf0, cf1, cf2;
`endif

   int checks   = 0;
   int failures = 0;

   sr_cmd_debouncer #(.DEBOUNCE_CYCLES(4), .PRIORITY(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .btn_set(btn_set), .btn_rst(btn_rst),
      .S(s0), .R(r0), .set_level(sl0), .rst_level(rl0)
`ifdef SR_CMD_CONFLICT_EN
      , .conflict(cf0)
`endif
   );

   sr_cmd_debouncer #(.DEBOUNCE_CYCLES(4), .PRIORITY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .btn_set(btn_set), .btn_rst(btn_rst),
      .S(s1), .R(r1), .set_level(sl1), .rst_level(rl1)
`ifdef SR_CMD_CONFLICT_EN
      , .conflict(cf1)
`endif
   );

   sr_cmd_debouncer #(.DEBOUNCE_CYCLES(4), .PRIORITY(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .btn_set(btn_set), .btn_rst(btn_rst),
      .S(s2), .R(r2), .set_level(sl2), .rst_level(rl2)
`ifdef SR_CMD_CONFLICT_EN
      , .conflict(cf2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // S and R must never be high together on any instance.
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if ((s0 & r0) | (s1 & r1) | (s2 & r2)) begin
            failures++;
            $display("FAIL sr_exclusive t=%0t got S&R=%b%b%b required=000", $time,
                     s0 & r0, s1 & r1, s2 & r2);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      btn_set = 1'b0;
      btn_rst = 1'b0;
      repeat (3) step();
      checks++;
      if ({s0, r0, sl0, rl0, s1, r1, sl1, rl1, s2, r2, sl2, rl2} !== 12'h000) begin
         failures++;
         $display("FAIL reset_outputs got=%b required=000000000000",
                  {s0, r0, sl0, rl0, s1, r1, sl1, rl1, s2, r2, sl2, rl2});
      end
      rst_n = 1'b1;
      repeat (3) step();
   endtask

   task automatic test_clean_press();
      logic [6:0] exp;
      btn_set = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         step();
         exp = {(e == 7), (e == 7), (e == 7), 3'b000, (e >= 7)};
         checks++;
         if ({s0, s1, s2, r0, r1, r2, sl1} !== exp) begin
            failures++;
            $display("FAIL clean_press e=%0d got=%b required=%b", e,
                     {s0, s1, s2, r0, r1, r2, sl1}, exp);
         end
      end
      btn_set = 1'b0;
      for (int e = 1; e <= 12; e++) begin
         step();
         exp = {6'b000000, (e < 7)};
         checks++;
         if ({s0, s1, s2, r0, r1, r2, sl1} !== exp) begin
            failures++;
            $display("FAIL clean_release e=%0d got=%b required=%b", e,
                     {s0, s1, s2, r0, r1, r2, sl1}, exp);
         end
      end
   endtask

   task automatic test_bounce();
      for (int i = 0; i < 8; i++) begin
         btn_set = ((i / 2) % 2 == 0);
         step();
         checks++;
         if ({s1, sl1} !== 2'b00) begin
            failures++;
            $display("FAIL bounce_quiet i=%0d got=%b required=00", i, {s1, sl1});
         end
      end
      btn_set = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         step();
         checks++;
         if (s1 !== (e == 7)) begin
            failures++;
            $display("FAIL bounce_final e=%0d got=%b required=%b", e, s1, (e == 7));
         end
      end
      btn_set = 1'b0;
      repeat (12) step();
   endtask

   task automatic test_glitch_boundary();
      btn_set = 1'b1;
      for (int e = 1; e <= 14; e++) begin
         if (e == 5) btn_set = 1'b0;
         step();
         checks++;
         if ({s1, sl1} !== 2'b00) begin
            failures++;
            $display("FAIL glitch_4cyc e=%0d got=%b required=00", e, {s1, sl1});
         end
      end
      btn_set = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         if (e == 6) btn_set = 1'b0;
         step();
         checks++;
         if (s1 !== (e == 7)) begin
            failures++;
            $display("FAIL glitch_5cyc e=%0d got=%b required=%b", e, s1, (e == 7));
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [5:0] exp;
      btn_set = 1'b1;
      btn_rst = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         step();
         exp = (e == 7) ? 6'b00_10_01 : 6'b00_00_00;
         checks++;
         if ({s0, r0, s1, r1, s2, r2} !== exp) begin
            failures++;
            $display("FAIL simultaneous e=%0d got=%b required=%b", e,
                     {s0, r0, s1, r1, s2, r2}, exp);
         end
`ifdef SR_CMD_CONFLICT_EN
         checks++;
         if ({cf0, cf1, cf2} !== {3{(e == 7)}}) begin
            failures++;
            $display("FAIL conflict e=%0d got=%b required=%b", e, {cf0, cf1, cf2},
                     {3{(e == 7)}});
         end
`endif
      end
      btn_set = 1'b0;
      btn_rst = 1'b0;
      for (int e = 1; e <= 12; e++) begin
         step();
         checks++;
         if ({s0, r0, s1, r1, s2, r2} !== 6'b000000) begin
            failures++;
            $display("FAIL simul_release e=%0d got=%b required=000000", e,
                     {s0, r0, s1, r1, s2, r2});
         end
      end
   endtask

   task automatic test_reset_in_press_chk();
      btn_set = 1'b1;
      repeat (5) step();
      rst_n = 1'b0;
      for (int e = 0; e <= 3; e++) begin
         if (e == 0) #1;
         else step();
         checks++;
         if ({s0, r0, sl0, rl0, s1, r1, sl1, rl1, s2, r2, sl2, rl2} !== 12'h000) begin
            failures++;
            $display("FAIL reset_mid_chk e=%0d got=%b required=000000000000", e,
                     {s0, r0, sl0, rl0, s1, r1, sl1, rl1, s2, r2, sl2, rl2});
         end
      end
      rst_n = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         step();
         checks++;
         if ({s1, r1, sl1} !== {(e == 7), 1'b0, (e >= 7)}) begin
            failures++;
            $display("FAIL reset_repress e=%0d got=%b required=%b", e, {s1, r1, sl1},
                     {(e == 7), 1'b0, (e >= 7)});
         end
      end
      btn_set = 1'b0;
      repeat (12) step();
   endtask

   task automatic test_async_reset();
      btn_set = 1'b1;
      repeat (7) step();
      checks++;
      if ({s1, sl1} !== 2'b11) begin
         failures++;
         $display("FAIL async_pre got=%b required=11", {s1, sl1});
      end
      rst_n = 1'b0;
      #2;
      checks++;
      if ({s0, s1, s2, sl0, sl1, sl2} !== 6'b000000) begin
         failures++;
         $display("FAIL async_clear got=%b required=000000", {s0, s1, s2, sl0, sl1, sl2});
      end
      step();
      rst_n = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         step();
         checks++;
         if (s1 !== (e == 7)) begin
            failures++;
            $display("FAIL async_repress e=%0d got=%b required=%b", e, s1, (e == 7));
         end
      end
      btn_set = 1'b0;
      repeat (12) step();
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp;
      btn_set = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         if (e == 11) btn_rst = 1'b1;
         if (e == 26) begin
            btn_set = 1'b0;
            btn_rst = 1'b0;
         end
         step();
         exp = {(e == 7), (e == 17), (e >= 7 && e < 32), (e >= 17 && e < 32)};
         checks++;
         if ({s1, r1, sl1, rl1} !== exp) begin
            failures++;
            $display("FAIL back_to_back e=%0d got=%b required=%b", e, {s1, r1, sl1, rl1}, exp);
         end
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      btn_set = 1'b0;
      btn_rst = 1'b0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_glitch_boundary();
      test_simultaneous();
      test_reset_in_press_chk();
      test_async_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
